// File: rtl/command_responder_if.sv
// Start/command/ready handshake and serial output bundle between the
// control sequencer (master) and command_responder (slave).
interface command_responder_if;
   logic [1:0] command_1;
   logic       start;
   logic       ready_command;
   logic       tx_bit;
   logic       tx_valid;
   logic       done;
   logic       overrun;

   modport master (
      output command_1,
      output start,
      input  ready_command,
      input  tx_bit,
      input  tx_valid,
      input  done,
      input  overrun
   );

   modport slave (
      input  command_1,
      input  start,
      output ready_command,
      output tx_bit,
      output tx_valid,
      output done,
      output overrun
   );
endinterface

// File: rtl/command_responder.sv
// Accepts a 2-bit command and serializes its fixed test symbol MSB first.
// Define CMD_RESPONDER_PARITY_EN to append an even-parity bit to each burst.
module command_responder #(
   parameter int unsigned CLKS_PER_BIT = 25,
   parameter logic [7:0]  PAT_1        = 8'hA5,
   parameter logic [7:0]  PAT_2        = 8'h0F,
   parameter logic [7:0]  PAT_3        = 8'h55
) (
   input logic               clk,
   input logic               rst,
   command_responder_if.slave bus
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef CMD_RESPONDER_PARITY_EN
   localparam int unsigned NumBits = 9;
`else
   localparam int unsigned NumBits = 8;
`endif
   localparam logic [CntW-1:0] CycLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      BitLast = 4'(NumBits - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cyc_q, cyc_d;
   logic [3:0]           bit_q, bit_d;
   logic [NumBits-1:0]   shift_q, shift_d;
   logic [1:0]           cmd_q, cmd_d;
   logic [7:0]           pat_sel;
   logic                 ready_q, ready_d;
   logic                 tx_bit_q, tx_bit_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 done_q, done_d;
   logic                 overrun_q, overrun_d;

   // Latched command is held for debug observation only.
   logic unused_cmd;
   assign unused_cmd = ^cmd_q;

   always_comb begin
      pat_sel = PAT_3;
      case (bus.command_1)
         2'b01:   pat_sel = PAT_1;
         2'b10:   pat_sel = PAT_2;
         default: pat_sel = PAT_3;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      cmd_d     = cmd_q;
      overrun_d = overrun_q | (bus.start & (state_q != StIdle));

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               cmd_d = bus.command_1;
               cyc_d = '0;
               bit_d = '0;
               if (bus.command_1 == 2'b00) begin
                  state_d = StDone;
               end else begin
`ifdef CMD_RESPONDER_PARITY_EN
                  shift_d = {pat_sel, ^pat_sel};
`else
                  shift_d = pat_sel;
`endif
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            if (cyc_q == CycLast) begin
               cyc_d   = '0;
               shift_d = {shift_q[NumBits-2:0], 1'b0};
               if (bit_q == BitLast) begin
                  bit_d   = '0;
                  state_d = StDone;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from next state so they register alongside it.
      ready_d    = (state_d == StIdle);
      tx_valid_d = (state_d == StShift);
      tx_bit_d   = (state_d == StShift) & shift_d[NumBits-1];
      done_d     = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cyc_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         cmd_q      <= '0;
         ready_q    <= 1'b1;
         tx_bit_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         cmd_q      <= cmd_d;
         ready_q    <= ready_d;
         tx_bit_q   <= tx_bit_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.ready_command = ready_q;
   assign bus.tx_bit        = tx_bit_q;
   assign bus.tx_valid      = tx_valid_q;
   assign bus.done          = done_q;
   assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_command_responder.sv
// Directed bench for command_responder with CLKS_PER_BIT=4; follows
// CMD_RESPONDER_PARITY_EN for burst length and parity expectations.
module tb_command_responder;

   localparam int unsigned Cpb = 4;
`ifdef CMD_RESPONDER_PARITY_EN
   localparam int unsigned NB = 9;
   localparam logic [7:0]  P3 = 8'h07;
`else
   localparam int unsigned NB = 8;
   localparam logic [7:0]  P3 = 8'h55;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   command_responder_if bus ();

   command_responder #(
      .CLKS_PER_BIT(Cpb),
      .PAT_1       (8'hA5),
      .PAT_2       (8'h0F),
      .PAT_3       (P3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Accept a command, check every bit cycle, then done and ready.
   // inject_at >= 0 pulses start (with a different command) after that step.
   task automatic run_burst(input logic [1:0] cmd, input logic [7:0] pat, input int inject_at);
      logic [NB-1:0] sym;
`ifdef CMD_RESPONDER_PARITY_EN
      sym = {pat, ^pat};
`else
      sym = pat;
`endif
      bus.command_1 = cmd;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      check("accept_ready", 32'(bus.ready_command), 32'd0);
      for (int i = 0; i < int'(NB * Cpb); i++) begin
         check($sformatf("cmd%0d_step%0d", cmd, i), 32'({bus.tx_valid, bus.tx_bit}),
               32'({1'b1, sym[NB - 1 - i / Cpb]}));
         if (i == inject_at) begin
            bus.start     = 1'b1;
            bus.command_1 = 2'b01;
         end
         tick;
         bus.start = 1'b0;
      end
      check("burst_done", 32'({bus.done, bus.ready_command, bus.tx_valid}), 32'b100);
      tick;
      check("burst_ready", 32'({bus.done, bus.ready_command, bus.tx_valid}), 32'b010);
   endtask

   initial begin
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.command_1 = 2'b00;
      repeat (2) tick;
      rst = 1'b1;
      tick;
      check("reset_ready", 32'(bus.ready_command), 32'd1);
      check("reset_outs", 32'({bus.tx_valid, bus.tx_bit, bus.done, bus.overrun}), 32'd0);

      run_burst(2'b01, 8'hA5, -1);
      check("no_overrun", 32'(bus.overrun), 32'd0);

      // NOP
      bus.command_1 = 2'b00;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      check("nop_done", 32'({bus.done, bus.ready_command, bus.tx_valid}), 32'b100);
      tick;
      check("nop_ready", 32'({bus.done, bus.ready_command, bus.tx_valid}), 32'b010);

      // start mid-burst is ignored but flags overrun
      run_burst(2'b10, 8'h0F, 9);
      check("overrun_set", 32'(bus.overrun), 32'd1);
      for (int j = 0; j < 3; j++) begin
         tick;
         check("no_second_burst", 32'({bus.done, bus.ready_command, bus.tx_valid}), 32'b010);
      end
      check("overrun_sticky", 32'(bus.overrun), 32'd1);

      // Reset during cycle 10 of a command 3 burst
      bus.command_1 = 2'b11;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      repeat (9) tick;
      check("pre_reset_valid", 32'(bus.tx_valid), 32'd1);
      rst = 1'b0;
      #1;
      check("async_reset_ready", 32'(bus.ready_command), 32'd1);
      check("async_reset_outs", 32'({bus.tx_valid, bus.tx_bit, bus.done, bus.overrun}), 32'd0);
      #2;
      rst = 1'b1;
      tick;
      check("post_reset_idle", 32'({bus.done, bus.ready_command, bus.tx_valid}), 32'b010);

      run_burst(2'b01, 8'hA5, -1);
      run_burst(2'b11, P3, -1);
      check("final_overrun", 32'(bus.overrun), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/command_responder.md
# command_responder

Far end of the start/command/ready handshake issued by the control sequencer. Accepts a 2-bit command on a `start` strobe and drops `ready_command` while it runs. Serializes the fixed 8-bit test symbol selected by the command onto a bit-timed serial line for the modulator path. Raises `ready_command` again when the burst completes, so the sequencer can issue the next command.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 25: clock cycles each serial bit is held; legal range ≥1.
- `PAT_1`, default 8'hA5: symbol for command 2'b01.
- `PAT_2`, default 8'h0F: symbol for command 2'b10.
- `PAT_3`, default 8'h55: symbol for command 2'b11.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset; asserts immediately, releases synchronously to `clk` by upstream synchronizer.
- `command_1` in 2: command code, sampled only on accept.
- `start` in 1: command request, level-sampled.
- `ready_command` out 1: high = idle and able to accept.
- `tx_bit` out 1: serial data, MSB first.
- `tx_valid` out 1: high while a bit of a burst is on `tx_bit`.
- `done` out 1: one-cycle pulse at command completion (NOP included).
- `overrun` out 1: sticky; set when `start`=1 while `ready_command`=0.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (any state, mid-burst included): state=IDLE; outputs `ready_command`=1, `tx_bit`=0, `tx_valid`=0, `done`=0, `overrun`=0; bit and cycle counters=0; latched command=0.
- IDLE: `ready_command`=1. Accept = rising edge with `start`=1. On accept, `command_1` is latched.
  - Command 2'b00 (NOP): next state DONE.
  - Commands 2'b01..2'b11: the matching pattern is loaded into the shift register, and next state is SHIFT.
- SHIFT: `tx_valid`=1, `tx_bit`=shift register MSB.
  - The cycle counter counts 0..CLKS_PER_BIT-1. At terminal count it wraps to 0 and the register shifts left one bit, zero-filled.
  - After the 8th bit's final cycle, next state is DONE.
- DONE: `done`=1 for exactly one cycle, `tx_valid`=0, `tx_bit`=0, `ready_command`=0; next state IDLE.
- `start` held high continuously: a new command is accepted on every IDLE cycle, giving back-to-back commands with one idle cycle between bursts.
- `start` asserted outside IDLE:
  - The request is ignored, never queued.
  - `overrun` is set and holds until reset.
  - The running burst is unaffected.
- `command_1` changes during SHIFT have no effect.
- Counters are sized to `$clog2(CLKS_PER_BIT)` bits (minimum 1) and a 4-bit bit index. No overflow is possible within a burst.

## Timing
- Accept at edge k: `ready_command`=0 from k+1.
- Data burst:
  - SHIFT occupies cycles k+1 .. k+8·CLKS_PER_BIT.
  - `done` is high at cycle k+8·CLKS_PER_BIT+1.
  - `ready_command`=1 from k+8·CLKS_PER_BIT+2.
- NOP: `done` at k+1; `ready_command`=1 from k+2.
- All outputs are registered. No combinational path from `start` or `command_1` to any output.

## Configuration
- `CMD_RESPONDER_PARITY_EN` defined:
  - SHIFT emits a 9th bit after the 8 data bits: even parity, i.e. XOR of the 8 data bits, held CLKS_PER_BIT cycles.
  - Burst length is 9·CLKS_PER_BIT. All data-burst latencies above use 9 in place of 8.
  - NOP timing is unchanged.
- Undefined: 8-bit bursts only; no parity logic is instantiated.

## Test plan
- Reset check, CLKS_PER_BIT=4: release `rst` → `ready_command`=1, `tx_valid`=0, `overrun`=0, `done`=0.
- Command 2'b01 with a 1-cycle `start`:
  - `tx_bit` sequence is 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - `done` pulses at k+33; `ready_command` rises at k+34.
- NOP, command 2'b00: `tx_valid` stays 0; `done` at k+1; ready again at k+2.
- `start` pulsed mid-burst of command 2'b10:
  - Burst stays 0,0,0,0,1,1,1,1.
  - `overrun`=1 and stays set.
  - No second burst follows.
- `rst` asserted at cycle 10 of a command 2'b11 burst: all outputs return to reset values in the same cycle. After release, command 2'b01 produces a clean 8'hA5 burst.
- With `CMD_RESPONDER_PARITY_EN`:
  - Command 2'b01 (8'hA5, four ones) appends parity bit 0; `done` at k+37.
  - Command 2'b11 with PAT_3=8'h07 appends parity bit 1.
